// File: rtl/byte_serializer.sv
// byte_serializer: latches a parallel word from byte_memory on a load
// handshake and drains it one bit per accepted beat over a valid/ready
// serial port, then pulses done for one cycle before returning to idle.
module byte_serializer #(
    parameter int BIT_COUNT = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [BIT_COUNT-1:0] memory,
    input  logic                 load_valid,
    output logic                 load_ready,
    output logic                 serial_out,
    output logic                 serial_valid,
    input  logic                 serial_ready,
    output logic                 frame_start,
    output logic                 busy,
    output logic                 done
);

    localparam int CW = $clog2(BIT_COUNT);
    localparam logic [CW-1:0] LAST = CW'(BIT_COUNT - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t               state, state_nx;
    logic [BIT_COUNT-1:0] sreg;
    logic [BIT_COUNT-1:0] sreg_shifted;
    logic [CW-1:0]        cnt;
    logic                 head;
    logic                 load_fire;
    logic                 accept;
    logic                 last;

    // Head bit sits at the end the word is drained from; the register moves
    // toward it and back-fills with zeros that are never presented.
    assign head         = MSB_FIRST ? sreg[BIT_COUNT-1] : sreg[0];
    assign sreg_shifted = MSB_FIRST ? {sreg[BIT_COUNT-2:0], 1'b0}
                                    : {1'b0, sreg[BIT_COUNT-1:1]};
    assign load_fire    = (state == IDLE) && load_valid;
    assign accept       = (state == SHIFT) && serial_ready;
    assign last         = (cnt == LAST);

    // State register; reset discards any word in flight.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next-state and handshake outputs, decoded from the current state.
    always_comb begin
        state_nx     = state;
        load_ready   = 1'b0;
        serial_valid = 1'b0;
        serial_out   = 1'b0;
        frame_start  = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (state)
            IDLE: begin
                load_ready = 1'b1;
                if (load_valid) state_nx = SHIFT;
            end
            SHIFT: begin
                busy         = 1'b1;
                serial_valid = 1'b1;
                serial_out   = head;
                frame_start  = (cnt == '0);
                if (serial_ready && last) state_nx = DONE;
            end
            DONE: begin
                busy     = 1'b1;
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Shift register and bit counter; a stalled beat holds both so the
    // presented bit is neither lost nor repeated.
    always_ff @(posedge clk) begin
        if (reset) begin
            sreg <= '0;
            cnt  <= '0;
        end else if (load_fire) begin
            sreg <= memory;
            cnt  <= '0;
        end else if (accept) begin
            sreg <= sreg_shifted;
            cnt  <= last ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: tb/tb_byte_serializer.sv
// Directed bench for byte_serializer: one LSB-first and one MSB-first
// instance share stimulus; each task checks the instance it targets.
module tb_byte_serializer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] memory = 8'h00;
    logic       load_valid = 1'b0;
    logic       serial_ready = 1'b0;

    logic l_load_ready, l_serial_out, l_serial_valid, l_frame_start, l_busy, l_done;
    logic m_load_ready, m_serial_out, m_serial_valid, m_frame_start, m_busy, m_done;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    byte_serializer #(.BIT_COUNT(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .reset(reset), .memory(memory),
        .load_valid(load_valid), .load_ready(l_load_ready),
        .serial_out(l_serial_out), .serial_valid(l_serial_valid),
        .serial_ready(serial_ready), .frame_start(l_frame_start),
        .busy(l_busy), .done(l_done)
    );

    byte_serializer #(.BIT_COUNT(8), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .reset(reset), .memory(memory),
        .load_valid(load_valid), .load_ready(m_load_ready),
        .serial_out(m_serial_out), .serial_valid(m_serial_valid),
        .serial_ready(serial_ready), .frame_start(m_frame_start),
        .busy(m_busy), .done(m_done)
    );

    task automatic test_reset();
        reset = 1'b1; load_valid = 1'b0; serial_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({l_load_ready, l_serial_valid, l_serial_out, l_frame_start, l_busy, l_done} !== 6'b100000) begin
            n_fail++;
            $display("FAIL reset_outputs got %b expected 100000",
                     {l_load_ready, l_serial_valid, l_serial_out, l_frame_start, l_busy, l_done});
        end
        n_checks++;
        if ({m_load_ready, m_serial_valid, m_busy, m_done} !== 4'b1000) begin
            n_fail++;
            $display("FAIL reset_outputs_msb got %b expected 1000",
                     {m_load_ready, m_serial_valid, m_busy, m_done});
        end
    endtask

    // Full word with serial_ready held high; done lands 9 cycles after the load edge.
    task automatic test_lsb_first();
        logic [7:0] exp;
        exp = 8'b1010_0101;  // bit order as sent for 8'hA5, first bit at [7]
        memory = 8'hA5; load_valid = 1'b1; serial_ready = 1'b1;
        @(negedge clk);
        load_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if ({l_serial_valid, l_serial_out, l_frame_start, l_load_ready, l_done} !==
                {1'b1, exp[7-i], (i == 0), 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL lsb_bit%0d got v=%b d=%b fs=%b lr=%b dn=%b expected v=1 d=%b fs=%b lr=0 dn=0",
                         i, l_serial_valid, l_serial_out, l_frame_start, l_load_ready, l_done, exp[7-i], (i == 0));
            end
            @(negedge clk);
        end
        n_checks++;
        if ({l_done, l_serial_valid, l_load_ready, l_busy} !== 4'b1001) begin
            n_fail++;
            $display("FAIL lsb_done_cycle got dn/v/lr/busy=%b expected 1001",
                     {l_done, l_serial_valid, l_load_ready, l_busy});
        end
        @(negedge clk);
        n_checks++;
        if ({l_done, l_load_ready, l_busy} !== 3'b010) begin
            n_fail++;
            $display("FAIL lsb_back_idle got dn/lr/busy=%b expected 010", {l_done, l_load_ready, l_busy});
        end
    endtask

    task automatic test_msb_first();
        logic [7:0] exp;
        exp = 8'b1000_0001;  // 8'h81 sent MSB first: 1,0,0,0,0,0,0,1
        memory = 8'h81; load_valid = 1'b1; serial_ready = 1'b1;
        @(negedge clk);
        load_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if ({m_serial_valid, m_serial_out, m_frame_start} !== {1'b1, exp[7-i], (i == 0)}) begin
                n_fail++;
                $display("FAIL msb_bit%0d got v=%b d=%b fs=%b expected v=1 d=%b fs=%b",
                         i, m_serial_valid, m_serial_out, m_frame_start, exp[7-i], (i == 0));
            end
            @(negedge clk);
        end
        n_checks++;
        if (m_done !== 1'b1) begin
            n_fail++;
            $display("FAIL msb_done got %b expected 1", m_done);
        end
        @(negedge clk);
    endtask

    // 8'h3C LSB first: 0,0,1,1,1,1,0,0; stall three cycles on bit 2.
    task automatic test_stall();
        logic [7:0] exp;
        exp = 8'b0011_1100;
        memory = 8'h3C; load_valid = 1'b1; serial_ready = 1'b1;
        @(negedge clk);
        load_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i == 2) begin
                serial_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    n_checks++;
                    if ({l_serial_valid, l_serial_out, l_frame_start, l_done} !== 4'b1100) begin
                        n_fail++;
                        $display("FAIL stall_hold%0d got v/d/fs/dn=%b expected 1100",
                                 s, {l_serial_valid, l_serial_out, l_frame_start, l_done});
                    end
                    @(negedge clk);
                end
                serial_ready = 1'b1;
            end
            n_checks++;
            if ({l_serial_valid, l_serial_out} !== {1'b1, exp[7-i]}) begin
                n_fail++;
                $display("FAIL stall_bit%0d got v=%b d=%b expected v=1 d=%b",
                         i, l_serial_valid, l_serial_out, exp[7-i]);
            end
            @(negedge clk);
        end
        n_checks++;
        if (l_done !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_done got %b expected 1", l_done);
        end
        @(negedge clk);
    endtask

    // Load attempt mid-word of 8'hC3 with memory=8'hFF; FF goes out only after done.
    task automatic test_ignored_load();
        logic [7:0] exp;
        exp = 8'b1100_0011;  // 8'hC3 LSB first: 1,1,0,0,0,0,1,1
        memory = 8'hC3; load_valid = 1'b1; serial_ready = 1'b1;
        @(negedge clk);
        load_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin
                memory = 8'hFF; load_valid = 1'b1;
            end
            n_checks++;
            if ({l_serial_out, l_load_ready} !== {exp[7-i], 1'b0}) begin
                n_fail++;
                $display("FAIL ignload_bit%0d got d=%b lr=%b expected d=%b lr=0",
                         i, l_serial_out, l_load_ready, exp[7-i]);
            end
            @(negedge clk);
        end
        n_checks++;
        if ({l_done, l_load_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL ignload_done got dn/lr=%b expected 10", {l_done, l_load_ready});
        end
        @(negedge clk);
        n_checks++;
        if ({l_load_ready, l_serial_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL ignload_idle got lr/v=%b expected 10", {l_load_ready, l_serial_valid});
        end
        @(negedge clk);
        load_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if ({l_serial_valid, l_serial_out} !== 2'b11) begin
                n_fail++;
                $display("FAIL ignload_ff_bit%0d got v/d=%b expected 11", i, {l_serial_valid, l_serial_out});
            end
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    // 8'h5A LSB first: 0,1,0,1,1,...; reset once bits 0..4 are accepted.
    task automatic test_reset_midword();
        int dones;
        memory = 8'h5A; load_valid = 1'b1; serial_ready = 1'b1;
        @(negedge clk);
        load_valid = 1'b0;
        repeat (5) @(negedge clk);
        n_checks++;
        if ({l_serial_valid, l_serial_out} !== 2'b10) begin
            n_fail++;
            $display("FAIL midrst_bit5 got v/d=%b expected 10", {l_serial_valid, l_serial_out});
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_checks++;
        if ({l_load_ready, l_serial_valid, l_serial_out, l_busy, l_done} !== 5'b10000) begin
            n_fail++;
            $display("FAIL midrst_idle got lr/v/d/busy/dn=%b expected 10000",
                     {l_load_ready, l_serial_valid, l_serial_out, l_busy, l_done});
        end
        dones = 0;
        for (int c = 0; c < 10; c++) begin
            if (l_done === 1'b1 || l_serial_valid === 1'b1) dones++;
            @(negedge clk);
        end
        n_checks++;
        if (dones !== 0) begin
            n_fail++;
            $display("FAIL midrst_quiet got %0d active cycles expected 0", dones);
        end
        // load_valid coincident with reset is dropped
        reset = 1'b1; load_valid = 1'b1; memory = 8'hFF;
        @(negedge clk);
        reset = 1'b0; load_valid = 1'b0;
        n_checks++;
        if ({l_load_ready, l_serial_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL rst_load_drop got lr/v=%b expected 10", {l_load_ready, l_serial_valid});
        end
    endtask

    // load_valid held high: frame starts must be BIT_COUNT+2 = 10 cycles apart.
    task automatic test_back_to_back();
        int gap;
        memory = 8'hA5; load_valid = 1'b1; serial_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (l_frame_start !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_first_frame got %b expected 1", l_frame_start);
        end
        gap = 0;
        do begin
            @(negedge clk);
            gap++;
        end while (l_frame_start !== 1'b1 && gap < 30);
        load_valid = 1'b0;
        n_checks++;
        if (gap !== 10) begin
            n_fail++;
            $display("FAIL b2b_interval got %0d cycles expected 10", gap);
        end
        repeat (12) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_lsb_first();
        test_msb_first();
        test_stall();
        test_ignored_load();
        test_reset_midword();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
